// File: rtl/fixed_point_div_stream_if.sv
// Operand/result stream bundle for the pipelined fixed-point divider.
// Both sides use valid/ready: a beat transfers on a rising clk edge where valid && ready.
interface fixed_point_div_stream_if #(
    parameter int WA   = 16,
    parameter int WB   = 16,
    parameter int WO   = 16,
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [WA-1:0]   dividend;
    logic [WB-1:0]   divisor;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [WO-1:0]   out;
    logic [TAGW-1:0] out_tag;
    logic            overflow;
    logic            div_zero;

    modport master (
        output in_valid, dividend, divisor, in_tag, out_ready,
        input  in_ready, out_valid, out, out_tag, overflow, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, in_tag, out_ready,
        output in_ready, out_valid, out, out_tag, overflow, div_zero
    );
endinterface

// File: rtl/fixed_point_div_stream.sv
// Pipelined signed fixed-point divider: operand stage, S restoring-division stages,
// round stage and saturate/output stage, all advancing together under one stall signal.
module fixed_point_div_stream #(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1,
    parameter int SPS   = 1,
    parameter int TAGW  = 4
) (
    input logic clk,
    input logic rst,
    fixed_point_div_stream_if.slave bus
);
    localparam int WA = WIIA + WIFA;
    localparam int WB = WIIB + WIFB;
    localparam int N  = WOI + WOF;
    localparam int S  = (N + SPS - 1) / SPS;
    localparam int F  = (WIFA > WIFB) ? WIFA : WIFB;
    localparam int GA = WIIA + F;
    localparam int GB = WIIB + F;
    localparam int W  = (((GA + WOF) > (GB + N)) ? (GA + WOF) : (GB + N)) + 1;
    localparam logic [N-1:0] ONE  = N'(1);
    localparam logic [N-1:0] MINN = ONE << (N - 1);
    localparam logic [N-1:0] MAXP = ~MINN;

    logic advance;
    assign advance     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    // Operand stage: magnitudes aligned onto a common grid of F fraction bits.
    logic [WA-1:0] a_abs;
    logic [WB-1:0] b_abs;
    logic [W-1:0]  ma, mb;
    logic          op_ov;
    assign a_abs = bus.dividend[WA-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign b_abs = bus.divisor[WB-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
    assign ma    = W'(a_abs) << (F - WIFA);
    assign mb    = W'(b_abs) << (F - WIFB);
    assign op_ov = ma >= (mb << WOI);

    // Index 0 is the operand stage, 1..S are the division stages.
    logic [W-1:0]    rem_q [0:S];
    logic [W-1:0]    dvs_q [0:S];
    logic [N-1:0]    quo_q [0:S];
    logic [TAGW-1:0] tag_q [0:S];
    logic [S:0]      vld_q, sgn_q, ovf_q, dz_q, az_q;

    logic [W-1:0] rem_n [1:S];
    logic [N-1:0] quo_n [1:S];
    logic [W-1:0] r_t, sh_t;
    logic [N-1:0] q_t;
    int           idx;

    always_comb begin
        r_t  = '0;
        q_t  = '0;
        sh_t = '0;
        idx  = 0;
        for (int s = 1; s <= S; s++) begin
            r_t = rem_q[s-1];
            q_t = quo_q[s-1];
            for (int k = 0; k < SPS; k++) begin
                idx  = N - 1 - (s - 1) * SPS - k;
                sh_t = '0;
                if (idx >= 0) begin
                    sh_t = dvs_q[s-1] << idx;
                    if (sh_t <= r_t) begin
                        r_t = r_t - sh_t;
                        q_t = q_t | (ONE << idx);
                    end
                end
            end
            rem_n[s] = r_t;
            quo_n[s] = q_t;
        end
    end

    // Round stage: half-up on the magnitude; the extra bit catches a carry to 2^N.
    logic         rnd_up;
    logic [N:0]   rq_n;
    assign rnd_up = (ROUND != 0) && ({rem_q[S], 1'b0} >= {1'b0, dvs_q[S]});
    assign rq_n   = {1'b0, quo_q[S]} + {{N{1'b0}}, rnd_up};

    logic [N:0]      rq_q;
    logic            r_vld, r_sgn, r_ovf, r_dz, r_az;
    logic [TAGW-1:0] r_tag;

    logic         mag_ov;
    logic [N-1:0] o_n;
    logic         ov_n;
    assign mag_ov = r_ovf || rq_q[N];

    always_comb begin
        o_n  = '0;
        ov_n = 1'b0;
        if (r_dz) begin
            if (!r_az) begin
                ov_n = 1'b1;
                o_n  = r_sgn ? MINN : MAXP;
            end
        end else if (!r_sgn) begin
            if (mag_ov || rq_q[N-1]) begin
                ov_n = 1'b1;
                o_n  = MAXP;
            end else begin
                o_n = rq_q[N-1:0];
            end
        end else begin
            if (mag_ov || (rq_q > {1'b0, MINN})) begin
                ov_n = 1'b1;
                o_n  = MINN;
            end else begin
                o_n = ~rq_q[N-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= S; s++) begin
                rem_q[s] <= '0;
                dvs_q[s] <= '0;
                quo_q[s] <= '0;
                tag_q[s] <= '0;
            end
            vld_q <= '0;
            sgn_q <= '0;
            ovf_q <= '0;
            dz_q  <= '0;
            az_q  <= '0;
            rq_q  <= '0;
            r_vld <= 1'b0;
            r_sgn <= 1'b0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
            r_az  <= 1'b0;
            r_tag <= '0;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_tag   <= '0;
            bus.overflow  <= 1'b0;
            bus.div_zero  <= 1'b0;
        end else if (advance) begin
            vld_q[0] <= bus.in_valid;
            rem_q[0] <= ma << WOF;
            dvs_q[0] <= mb;
            quo_q[0] <= '0;
            tag_q[0] <= bus.in_tag;
            sgn_q[0] <= bus.dividend[WA-1] ^ bus.divisor[WB-1];
            ovf_q[0] <= op_ov;
            dz_q[0]  <= (b_abs == '0);
            az_q[0]  <= (a_abs == '0);
            for (int s = 1; s <= S; s++) begin
                rem_q[s] <= rem_n[s];
                quo_q[s] <= quo_n[s];
                dvs_q[s] <= dvs_q[s-1];
                tag_q[s] <= tag_q[s-1];
                vld_q[s] <= vld_q[s-1];
                sgn_q[s] <= sgn_q[s-1];
                ovf_q[s] <= ovf_q[s-1];
                dz_q[s]  <= dz_q[s-1];
                az_q[s]  <= az_q[s-1];
            end
            rq_q  <= rq_n;
            r_vld <= vld_q[S];
            r_sgn <= sgn_q[S];
            r_ovf <= ovf_q[S];
            r_dz  <= dz_q[S];
            r_az  <= az_q[S];
            r_tag <= tag_q[S];
            bus.out_valid <= r_vld;
            bus.out       <= o_n;
            bus.out_tag   <= r_tag;
            bus.overflow  <= ov_n;
            bus.div_zero  <= r_dz;
        end
    end
endmodule

// File: tb/tb_fixed_point_div_stream.sv
// Bench for fixed_point_div_stream in Q8.8: directed corner cases, random stream with
// backpressure against an integer-arithmetic model, latency and reset behaviour.
module tb_fixed_point_div_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_point_div_stream_if #(.WA(16), .WB(16), .WO(16), .TAGW(4)) if_a ();
  fixed_point_div_stream_if #(.WA(16), .WB(16), .WO(16), .TAGW(4)) if_b ();

  fixed_point_div_stream u_dut (.clk(clk), .rst(rst), .bus(if_a));
  fixed_point_div_stream #(.SPS(2), .ROUND(0)) u_alt (.clk(clk), .rst(rst), .bus(if_b));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: value a/256 divided by b/256, scaled by 256 -> floor(|a|*256/|b|).
  function automatic logic [21:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input bit rnd, input logic [3:0] tag);
    longint av, bv, num, den, q, r, res;
    logic [15:0] o;
    bit ov, dz;
    av = longint'($signed(a));
    bv = longint'($signed(b));
    o = '0; ov = 0; dz = 0;
    if (bv == 0) begin
      dz = 1;
      if (av > 0) begin o = 16'h7FFF; ov = 1; end
      else if (av < 0) begin o = 16'h8000; ov = 1; end
    end else begin
      num = (av < 0 ? -av : av) * 256;
      den = (bv < 0 ? -bv : bv);
      q = num / den;
      r = num % den;
      if (rnd && (2 * r >= den)) q++;
      res = ((av < 0) != (bv < 0)) ? -q : q;
      if (res > 32767) begin o = 16'h7FFF; ov = 1; end
      else if (res < -32768) begin o = 16'h8000; ov = 1; end
      else o = res[15:0];
    end
    return {tag, ov, dz, o};
  endfunction

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  logic [21:0] mon_e;
  int          n_outs = 0;
  int          acc_cyc = 0;
  bit          rand_ready = 0;
  bit          ready_level = 1;

  always @(posedge clk) begin
    #1;
    if_a.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Every cycle a result is presented it must equal the head of the queue, stalled or not.
  always @(negedge clk) begin
    if (!rst && if_a.out_valid) begin
      n_outs++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        mon_e = exp_q[0];
        check_val("out", if_a.out, mon_e[15:0]);
        check_val("div_zero", if_a.div_zero, mon_e[16]);
        check_val("overflow", if_a.overflow, mon_e[17]);
        check_val("tag", if_a.out_tag, mon_e[21:18]);
        if (if_a.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                      input logic [21:0] exp);
    bit ok;
    ok = 0;
    if_a.in_valid = 1'b1;
    if_a.dividend = a;
    if_a.divisor  = b;
    if_a.in_tag   = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_a.in_ready) begin ok = 1; break; end
    end
    if (!ok) check_val("in_ready_timeout", 0, 1);
    else begin
      exp_q.push_back(exp);
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    send(a, b, tag, model(a, b, 1, tag));
  endtask

  task automatic wait_out_a(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_a.out_valid) begin lat = cyc - acc_cyc; break; end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check_val("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic alt_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_out,
                        input int exp_lat);
    int t0;
    int lat;
    if_b.in_valid = 1'b1;
    if_b.dividend = a;
    if_b.divisor  = b;
    if_b.in_tag   = 4'h5;
    @(negedge clk);
    check_val("alt_in_ready", if_b.in_ready, 1);
    t0 = cyc;
    @(posedge clk); #1;
    if_b.in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_b.out_valid) begin lat = cyc - t0; break; end
    end
    check_val("alt_latency", lat, exp_lat);
    check_val("alt_out", if_b.out, exp_out);
    check_val("alt_overflow", if_b.overflow, 0);
    check_val("alt_tag", if_b.out_tag, 4'h5);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int snap;
    logic [15:0] ra, rb;
    if_a.in_valid = 1'b0; if_a.dividend = '0; if_a.divisor = '0; if_a.in_tag = '0;
    if_b.in_valid = 1'b0; if_b.dividend = '0; if_b.divisor = '0; if_b.in_tag = '0;
    if_b.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", if_a.out_valid, 0);
    check_val("rst_out", if_a.out, 0);
    check_val("rst_out_tag", if_a.out_tag, 0);
    check_val("rst_overflow", if_a.overflow, 0);
    check_val("rst_div_zero", if_a.div_zero, 0);
    check_val("rst_in_ready", if_a.in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    send(16'h0300, 16'h0200, 4'h1, {4'h1, 1'b0, 1'b0, 16'h0180});
    wait_out_a(lat);
    check_val("latency_sps1", lat, 19);
    drain();

    send(16'h0200, 16'h0300, 4'h2, {4'h2, 1'b0, 1'b0, 16'h00AB});
    send(16'hFF00, 16'h0300, 4'h3, {4'h3, 1'b0, 1'b0, 16'hFFAB});
    send(16'h6400, 16'h0040, 4'h4, {4'h4, 1'b1, 1'b0, 16'h7FFF});
    send(16'h8000, 16'h0100, 4'h5, {4'h5, 1'b0, 1'b0, 16'h8000});
    send(16'h8000, 16'hFF00, 4'h6, {4'h6, 1'b1, 1'b0, 16'h7FFF});
    send(16'h0500, 16'h0000, 4'h7, {4'h7, 1'b1, 1'b1, 16'h7FFF});
    send(16'h0000, 16'h0000, 4'h8, {4'h8, 1'b0, 1'b1, 16'h0000});
    send(16'hFB00, 16'h0000, 4'h9, {4'h9, 1'b1, 1'b1, 16'h8000});
    drain();

    alt_op(16'h0300, 16'h0200, 16'h0180, 11);
    alt_op(16'h0200, 16'h0300, 16'h00AA, 11);

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1, 2:    rb = 16'($urandom_range(1, 255));
        3:       rb = -16'($urandom_range(1, 255));
        default: rb = 16'($urandom);
      endcase
      send_model(ra, rb, 4'(i));
    end
    drain();
    rand_ready = 0;

    // Reset with ten operations in flight and a stalled result at the output.
    ready_level = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send_model(16'($urandom), 16'($urandom_range(1, 4000)), 4'(i));
    for (int i = 0; i < 60 && !if_a.out_valid; i++) @(negedge clk);
    check_val("rst_fill_out_valid", if_a.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_out_valid", if_a.out_valid, 0);
    check_val("async_rst_out", if_a.out, 0);
    check_val("async_rst_in_ready", if_a.in_ready, 1);
    exp_q.delete();
    ready_level = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    snap = n_outs;
    repeat (40) @(negedge clk);
    check_val("quiet_after_rst", n_outs - snap, 0);
    @(posedge clk); #1;
    send_model(16'h0300, 16'h0200, 4'hC);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fixed_point_div_stream.md
FIXED_POINT_DIV_STREAM -- requirements
Module: fixed_point_div_stream

Interface
REQ-001 SHALL have parameter WIIA, default 8, meaning dividend integer bits (incl. sign).
REQ-002 SHALL have parameter WIFA, default 8, meaning dividend fraction bits.
REQ-003 SHALL have parameter WIIB, default 8, meaning divisor integer bits (incl. sign).
REQ-004 SHALL have parameter WIFB, default 8, meaning divisor fraction bits.
REQ-005 SHALL have parameter WOI, default 8, meaning result integer bits (incl. sign).
REQ-006 SHALL have parameter WOF, default 8, meaning result fraction bits.
REQ-007 SHALL have parameter ROUND, default 1, meaning 1 = round-half-up on magnitude, 0 = truncate.
REQ-008 SHALL have parameter SPS, default 1, legal 1..4, meaning quotient bits resolved per division stage.
REQ-009 SHALL have parameter TAGW, default 4, meaning width of the sideband tag.
REQ-010 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-011 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-012 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-013 SHALL have port in_ready, output, 1 bit: block accepts an operand pair this cycle.
REQ-014 SHALL have port dividend, input, WIIA+WIFA bits: two's-complement dividend.
REQ-015 SHALL have port divisor, input, WIIB+WIFB bits: two's-complement divisor.
REQ-016 SHALL have port in_tag, input, TAGW bits: sideband tag carried with the operands.
REQ-017 SHALL have port out_valid, output, 1 bit: result present.
REQ-018 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-019 SHALL have port out, output, WOI+WOF bits: two's-complement quotient.
REQ-020 SHALL have port out_tag, output, TAGW bits: tag of the result.
REQ-021 SHALL have port overflow, output, 1 bit: result was saturated.
REQ-022 SHALL have port div_zero, output, 1 bit: divisor was zero.

Function
REQ-023 SHALL define N=WOI+WOF and S=ceil(N/SPS); the pipeline is 1 operand stage, S division stages, 1 round stage and 1 saturate/output stage, for a latency of S+3 cycles when not stalled.
REQ-024 SHALL derive advance = !out_valid || out_ready, drive in_ready = advance, and have every stage register (data, tag and valid bit) load only when advance=1.
REQ-025 SHALL capture a transfer on in_valid && in_ready and retire a result on out_valid && out_ready; no result may be dropped, duplicated or reordered.
REQ-026 SHALL hold out, out_tag, overflow and div_zero stable while out_valid=1 && out_ready=0.
REQ-027 SHALL let bubbles (stages with valid=0) occupy slots; no bubble compaction is required.
REQ-028 SHALL convert operands to magnitudes in the operand stage, align both to a common fixed-point grid without loss, and compute result sign = sign(dividend) XOR sign(divisor).
REQ-029 SHALL, in the division stages, use restoring division that sets a quotient bit when the shifted divisor is less than or equal to the remainder, so that the magnitude is q = floor(|a|*2^WOF/|b|).
REQ-030 SHALL flag a magnitude overflow when |a| >= |b|*2^WOI, detected in the operand stage and carried down the pipeline.
REQ-031 SHALL, when ROUND=1, increment q when 2*remainder >= |b| (in grid units); a carry to 2^N SHALL be treated as a magnitude overflow.
REQ-032 SHALL saturate as follows: for a positive result, q > 2^(N-1)-1 or magnitude overflow gives out = 0x7F..F with overflow=1; for a negative result, q > 2^(N-1) or magnitude overflow gives out = 0x80..0 with overflow=1; a negative q of exactly 2^(N-1) gives 0x80..0 with overflow=0; otherwise out = ±q with overflow=0.
REQ-033 SHALL, when divisor=0, set div_zero=1 and produce 0x7F..F with overflow=1 for a dividend > 0, 0x80..0 with overflow=1 for a dividend < 0, and 0 with overflow=0 for a dividend of 0.
REQ-034 SHALL copy in_tag unchanged to out_tag with the same latency as the data.

Reset
REQ-035 SHALL, while rst=1, immediately clear out_valid, out, out_tag, overflow, div_zero and all stage valid bits to 0, and drive in_ready=1 once out_valid=0.
REQ-036 SHALL discard all in-flight operations on reset mid-operation, and SHALL emit no stale result after reset is released.

Verification (Q8.8 in/out, SPS=1, so latency 19, unless stated)
REQ-037 SHALL cover: 0x0300 / 0x0200 -> out=0x0180, overflow=0, out_valid exactly 19 cycles after acceptance; with SPS=2, latency is 11.
REQ-038 SHALL cover: 0x0200 / 0x0300 -> out=0x00AB with ROUND=1 and 0x00AA with ROUND=0; 0xFF00 / 0x0300 -> out=0xFFAB.
REQ-039 SHALL cover: 0x6400 / 0x0040 -> out=0x7FFF, overflow=1; 0x8000 / 0x0100 -> out=0x8000, overflow=0; 0x8000 / 0xFF00 -> out=0x7FFF, overflow=1.
REQ-040 SHALL cover: 0x0500 / 0x0000 -> out=0x7FFF, div_zero=1, overflow=1; 0x0000 / 0x0000 -> out=0x0000, div_zero=1, overflow=0.
REQ-041 SHALL cover: 40 back-to-back random operand pairs with tags 0..F and out_ready randomly toggled -> all 40 results match a reference model, in order with correct tags, and outputs stay stable during stalls.
REQ-042 SHALL cover: rst pulsed while 10 operations are in flight -> out_valid=0 asynchronously, and no result appears until new operands are accepted.
